// File: rtl/pe_fetch_queue.sv
// pe_fetch_queue: DEPTH-entry fetch queue between the main controller and the multiply stage.
// Optional macro FS_STALL_CNT_EN adds o_stall_cnt, a saturating count of head-stall cycles.
module pe_fetch_queue #(
  parameter int NROW    = 4,
  parameter int DWD     = 16,
  parameter int PSUMDWD = 32,
  parameter int NUMTW   = 4,
  parameter int DEPTH   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         MAIN_rdy,
  output logic                         MAIN_ack,
  input  logic [1:0]                   i_mode,
  input  logic [NUMTW-1:0]             i_inumt,
  input  logic [NUMTW-1:0]             i_wnumt,
  input  logic [1:0]                   i_psum_mode,
  input  logic [1:0]                   i_psum_sel,
  input  logic [NROW*DWD-1:0]          i_input,
  input  logic [NROW*DWD-1:0]          i_weight,
  input  logic [NROW*PSUMDWD-1:0]      i_psum,
  output logic                         FS_rdy,
  input  logic                         FS_ack,
  output logic [1:0]                   o_mode,
  output logic [NUMTW-1:0]             o_inumt,
  output logic [NUMTW-1:0]             o_wnumt,
  output logic [63:0]                  o_aumask,
  output logic [NROW*DWD-1:0]          o_input,
  output logic [NROW*DWD-1:0]          o_weight,
  output logic [NROW*PSUMDWD-1:0]      o_psum,
  output logic [$clog2(DEPTH):0]       o_count
`ifdef FS_STALL_CNT_EN
  ,
  output logic [15:0]                  o_stall_cnt
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int IW  = NROW * DWD;
  localparam int PSW = NROW * PSUMDWD;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;
  logic          full;

  logic [1:0]       mode_mem   [DEPTH];
  logic [NUMTW-1:0] inumt_mem  [DEPTH];
  logic [NUMTW-1:0] wnumt_mem  [DEPTH];
  logic [63:0]      mask_mem   [DEPTH];
  logic [IW-1:0]    input_mem  [DEPTH];
  logic [IW-1:0]    weight_mem [DEPTH];
  logic [PSW-1:0]   psum_mem   [DEPTH];

  logic [63:0]  mask_next;
  logic [PSW-1:0] psum_next;

  // A full queue refuses the beat even when the head pops in the same cycle.
  assign full     = (count_reg == CW'(DEPTH));
  assign MAIN_ack = MAIN_rdy && !full && !i_rst;
  assign FS_rdy   = (count_reg != '0);
  assign push     = MAIN_ack;
  assign pop      = FS_rdy && FS_ack && !i_rst;

  always_comb begin
    case (i_mode)
      2'd2:    mask_next = 64'h0000_0000_ffff_0000;
      2'd3:    mask_next = 64'h0000_ffff_0000_0000;
      default: mask_next = 64'h0000_0000_0000_ffff;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NROW; gi++) begin : g_psum_lane
      logic [PSUMDWD-1:0] word;
      logic [PSUMDWD-1:0] half_sh;
      logic [PSUMDWD-1:0] quarter_sh;
      logic [PSUMDWD-1:0] lane;

      always_comb begin
        word       = i_psum[gi*PSUMDWD +: PSUMDWD];
        half_sh    = i_psum_sel[0] ? (word >> DWD) : word;
        quarter_sh = word >> (32'(i_psum_sel) * (DWD / 2));
        case (i_psum_mode)
          2'd1:    lane = PSUMDWD'(half_sh[DWD-1:0]);
          2'd2:    lane = PSUMDWD'(quarter_sh[DWD/2-1:0]);
          default: lane = word;
        endcase
      end

      assign psum_next[gi*PSUMDWD +: PSUMDWD] = lane;
    end
  endgenerate

  // Entry storage is never cleared; the head is gated to zero while empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mode_mem[wr_ptr_reg]   <= i_mode;
      inumt_mem[wr_ptr_reg]  <= i_inumt;
      wnumt_mem[wr_ptr_reg]  <= i_wnumt;
      mask_mem[wr_ptr_reg]   <= mask_next;
      input_mem[wr_ptr_reg]  <= i_input;
      weight_mem[wr_ptr_reg] <= i_weight;
      psum_mem[wr_ptr_reg]   <= psum_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign o_count  = count_reg;
  assign o_mode   = FS_rdy ? mode_mem[rd_ptr_reg]   : '0;
  assign o_inumt  = FS_rdy ? inumt_mem[rd_ptr_reg]  : '0;
  assign o_wnumt  = FS_rdy ? wnumt_mem[rd_ptr_reg]  : '0;
  assign o_aumask = FS_rdy ? mask_mem[rd_ptr_reg]   : '0;
  assign o_input  = FS_rdy ? input_mem[rd_ptr_reg]  : '0;
  assign o_weight = FS_rdy ? weight_mem[rd_ptr_reg] : '0;
  assign o_psum   = FS_rdy ? psum_mem[rd_ptr_reg]   : '0;

`ifdef FS_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_reg <= '0;
    end else if (FS_rdy && !FS_ack && (stall_cnt_reg != 16'hffff)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pe_fetch_queue.sv
// Self-checking bench for pe_fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pe_fetch_queue;

  localparam int NROW    = 4;
  localparam int DWD     = 16;
  localparam int PSUMDWD = 32;
  localparam int NUMTW   = 4;
  localparam int DEPTH   = 2;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int IW      = NROW * DWD;
  localparam int PSW     = NROW * PSUMDWD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             main_rdy;
  logic             main_ack;
  logic [1:0]       mode;
  logic [NUMTW-1:0] inumt;
  logic [NUMTW-1:0] wnumt;
  logic [1:0]       psum_mode;
  logic [1:0]       psum_sel;
  logic [IW-1:0]    in_w;
  logic [IW-1:0]    wt_w;
  logic [PSW-1:0]   ps_w;
  logic             fs_rdy;
  logic             fs_ack;
  logic [1:0]       o_mode;
  logic [NUMTW-1:0] o_inumt;
  logic [NUMTW-1:0] o_wnumt;
  logic [63:0]      o_aumask;
  logic [IW-1:0]    o_input;
  logic [IW-1:0]    o_weight;
  logic [PSW-1:0]   o_psum;
  logic [CW-1:0]    o_count;
`ifdef FS_STALL_CNT_EN
  logic [15:0]      o_stall_cnt;
  int               stall_model = 0;
`endif

  pe_fetch_queue #(
    .NROW(NROW), .DWD(DWD), .PSUMDWD(PSUMDWD), .NUMTW(NUMTW), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .MAIN_rdy(main_rdy), .MAIN_ack(main_ack),
    .i_mode(mode), .i_inumt(inumt), .i_wnumt(wnumt),
    .i_psum_mode(psum_mode), .i_psum_sel(psum_sel),
    .i_input(in_w), .i_weight(wt_w), .i_psum(ps_w),
    .FS_rdy(fs_rdy), .FS_ack(fs_ack),
    .o_mode(o_mode), .o_inumt(o_inumt), .o_wnumt(o_wnumt), .o_aumask(o_aumask),
    .o_input(o_input), .o_weight(o_weight), .o_psum(o_psum), .o_count(o_count)
`ifdef FS_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]       mode;
    logic [NUMTW-1:0] inumt;
    logic [NUMTW-1:0] wnumt;
    logic [63:0]      mask;
    logic [IW-1:0]    inp;
    logic [IW-1:0]    wgt;
    logic [PSW-1:0]   psum;
  } beat_t;

  beat_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [63:0] exp_mask(logic [1:0] m);
    if (m == 2'd0) return 64'hffff;
    return 64'hffff << (16 * (int'(m) - 1));
  endfunction

  function automatic logic [PSW-1:0] exp_psum(logic [PSW-1:0] p, logic [1:0] pm, logic [1:0] sel);
    logic [PSW-1:0] res;
    longint unsigned v;
    res = '0;
    for (int r = 0; r < NROW; r++) begin
      v = 64'(p[r*PSUMDWD +: PSUMDWD]);
      if (pm == 2'd1)      v = (v >> (int'(sel[0]) * DWD)) % (64'd1 << DWD);
      else if (pm == 2'd2) v = (v >> (int'(sel) * DWD / 2)) % (64'd1 << (DWD / 2));
      res[r*PSUMDWD +: PSUMDWD] = PSUMDWD'(v);
    end
    return res;
  endfunction

  function automatic beat_t model_beat();
    beat_t b;
    b.mode  = mode;
    b.inumt = inumt;
    b.wnumt = wnumt;
    b.mask  = exp_mask(mode);
    b.inp   = in_w;
    b.wgt   = wt_w;
    b.psum  = exp_psum(ps_w, psum_mode, psum_sel);
    return b;
  endfunction

  task automatic rand_inputs();
    mode      = 2'($urandom);
    inumt     = NUMTW'($urandom);
    wnumt     = NUMTW'($urandom);
    psum_mode = 2'($urandom);
    psum_sel  = 2'($urandom);
    for (int r = 0; r < NROW; r++) begin
      in_w[r*DWD +: DWD]         = DWD'($urandom);
      wt_w[r*DWD +: DWD]         = DWD'($urandom);
      ps_w[r*PSUMDWD +: PSUMDWD] = PSUMDWD'($urandom);
    end
  endtask

  // Advance one clock edge and update the reference model with what that edge does.
  task automatic cycle();
    bit    do_push;
    bit    do_pop;
    beat_t b;
    do_push = !rst && main_rdy && (q.size() < DEPTH);
    do_pop  = !rst && fs_ack && (q.size() != 0);
    b = model_beat();
`ifdef FS_STALL_CNT_EN
    if (rst) stall_model = 0;
    else if (q.size() != 0 && !fs_ack && stall_model < 65535) stall_model++;
`endif
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; main_rdy = 1'b1; fs_ack = 1'b0;
    rand_inputs();
    for (int k = 0; k < 2; k++) begin
      #2;
      n_total++;
      if (main_ack !== 1'b0) $display("FAIL reset_ack: got %0b want 0", main_ack);
      else n_pass++;
      cycle();
    end
    rst = 1'b0; main_rdy = 1'b0;
    #2;
    n_total++;
    if (fs_rdy !== 1'b0 || o_count !== '0) $display("FAIL reset_rdy_count: got rdy=%0b count=%0d want 0/0", fs_rdy, o_count);
    else n_pass++;
    n_total++;
    if ({o_mode, o_inumt, o_wnumt, o_aumask} !== '0) $display("FAIL reset_ctrl: got %h want 0", {o_mode, o_inumt, o_wnumt, o_aumask});
    else n_pass++;
    n_total++;
    if ({o_input, o_weight, o_psum} !== '0) $display("FAIL reset_data: got %h want 0", {o_input, o_weight, o_psum});
    else n_pass++;
    cycle();
  endtask

  task automatic test_mask();
    logic [63:0] mask_tab [4];
    mask_tab[0] = 64'h0000_0000_0000_ffff;
    mask_tab[1] = 64'h0000_0000_0000_ffff;
    mask_tab[2] = 64'h0000_0000_ffff_0000;
    mask_tab[3] = 64'h0000_ffff_0000_0000;
    fs_ack = 1'b1;
    for (int m = 0; m < 4; m++) begin
      rand_inputs();
      mode = 2'(m);
      main_rdy = 1'b1;
      cycle();
      #2;
      n_total++;
      if (o_aumask !== mask_tab[m] || o_mode !== 2'(m))
        $display("FAIL mask_mode%0d: got mask=%h mode=%0d want mask=%h mode=%0d", m, o_aumask, o_mode, mask_tab[m], m);
      else n_pass++;
    end
    main_rdy = 1'b0;
    cycle();
  endtask

  task automatic test_psum();
    logic [1:0]     pm_tab  [3];
    logic [1:0]     sel_tab [3];
    logic [PSW-1:0] exp_tab [3];
    pm_tab[0] = 2'd1; sel_tab[0] = 2'd1; exp_tab[0] = {NROW{32'h0000_1234}};
    pm_tab[1] = 2'd2; sel_tab[1] = 2'd3; exp_tab[1] = {NROW{32'h0000_0012}};
    pm_tab[2] = 2'd0; sel_tab[2] = 2'd2; exp_tab[2] = {NROW{32'h1234_5678}};
    fs_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      ps_w = {NROW{32'h1234_5678}};
      psum_mode = pm_tab[k];
      psum_sel  = sel_tab[k];
      main_rdy  = 1'b1;
      cycle();
      #2;
      n_total++;
      if (o_psum !== exp_tab[k]) $display("FAIL psum_case%0d: got %h want %h", k, o_psum, exp_tab[k]);
      else n_pass++;
    end
    main_rdy = 1'b0;
    cycle();
  endtask

  task automatic test_fill();
    logic [IW-1:0] tags [3];
    fs_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      tags[k] = in_w;
      main_rdy = 1'b1;
      #2;
      n_total++;
      if (main_ack !== (k < 2)) $display("FAIL fill_ack%0d: got %0b want %0b", k, main_ack, (k < 2));
      else n_pass++;
      cycle();
    end
    #2;
    n_total++;
    if (o_count !== CW'(2) || o_input !== tags[0]) $display("FAIL fill_full: got count=%0d head=%h want 2/%h", o_count, o_input, tags[0]);
    else n_pass++;
    fs_ack = 1'b1;
    #1;
    n_total++;
    if (main_ack !== 1'b0) $display("FAIL fill_full_pop_ack: got %0b want 0", main_ack);
    else n_pass++;
    cycle();
    fs_ack = 1'b0;
    #2;
    n_total++;
    if (main_ack !== 1'b1 || o_input !== tags[1]) $display("FAIL fill_reaccept: got ack=%0b head=%h want 1/%h", main_ack, o_input, tags[1]);
    else n_pass++;
    cycle();
    main_rdy = 1'b0; fs_ack = 1'b1;
    #2;
    n_total++;
    if (o_count !== CW'(2) || o_input !== tags[1]) $display("FAIL fill_order1: got count=%0d head=%h want 2/%h", o_count, o_input, tags[1]);
    else n_pass++;
    cycle();
    #2;
    n_total++;
    if (o_count !== CW'(1) || o_input !== tags[2]) $display("FAIL fill_order2: got count=%0d head=%h want 1/%h", o_count, o_input, tags[2]);
    else n_pass++;
    cycle();
    #2;
    n_total++;
    if (fs_rdy !== 1'b0 || o_input !== '0) $display("FAIL fill_drained: got rdy=%0b head=%h want 0/0", fs_rdy, o_input);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] cur;
    fs_ack = 1'b0;
    rand_inputs();
    main_rdy = 1'b1;
    cycle();
    fs_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_inputs();
      cur = in_w;
      #2;
      n_total++;
      if (main_ack !== 1'b1 || fs_rdy !== 1'b1) $display("FAIL b2b_hs%0d: got ack=%0b rdy=%0b want 1/1", k, main_ack, fs_rdy);
      else n_pass++;
      cycle();
      #2;
      n_total++;
      if (o_count !== CW'(1) || o_input !== cur) $display("FAIL b2b_head%0d: got count=%0d head=%h want 1/%h", k, o_count, o_input, cur);
      else n_pass++;
    end
    main_rdy = 1'b0;
    cycle();
  endtask

`ifdef FS_STALL_CNT_EN
  task automatic test_stall();
    rst = 1'b1; main_rdy = 1'b0; fs_ack = 1'b0;
    cycle();
    rst = 1'b0;
    rand_inputs();
    main_rdy = 1'b1;
    cycle();
    main_rdy = 1'b0;
    repeat (5) cycle();
    #2;
    n_total++;
    if (o_stall_cnt !== 16'd5) $display("FAIL stall_count: got %0d want 5", o_stall_cnt);
    else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #2;
    n_total++;
    if (o_stall_cnt !== 16'd0) $display("FAIL stall_reset: got %0d want 0", o_stall_cnt);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    beat_t e;
    bit    exp_rdy;
    bit    exp_ack;
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      rst      = ($urandom_range(0, 49) == 0);
      main_rdy = ($urandom_range(0, 3) != 0);
      fs_ack   = ($urandom_range(0, 2) != 0);
      #2;
      exp_rdy = (q.size() != 0);
      exp_ack = !rst && main_rdy && (q.size() < DEPTH);
      e = exp_rdy ? q[0] : '0;
      n_total++;
      if (fs_rdy !== exp_rdy || main_ack !== exp_ack)
        $display("FAIL rnd_hs@%0d: got rdy=%0b ack=%0b want %0b/%0b", k, fs_rdy, main_ack, exp_rdy, exp_ack);
      else n_pass++;
      n_total++;
      if (o_count !== CW'(q.size())) $display("FAIL rnd_count@%0d: got %0d want %0d", k, o_count, q.size());
      else n_pass++;
      n_total++;
      if ({o_mode, o_inumt, o_wnumt} !== {e.mode, e.inumt, e.wnumt})
        $display("FAIL rnd_ctrl@%0d: got %h want %h", k, {o_mode, o_inumt, o_wnumt}, {e.mode, e.inumt, e.wnumt});
      else n_pass++;
      n_total++;
      if (o_aumask !== e.mask) $display("FAIL rnd_mask@%0d: got %h want %h", k, o_aumask, e.mask);
      else n_pass++;
      n_total++;
      if (o_input !== e.inp || o_weight !== e.wgt)
        $display("FAIL rnd_data@%0d: got %h/%h want %h/%h", k, o_input, o_weight, e.inp, e.wgt);
      else n_pass++;
      n_total++;
      if (o_psum !== e.psum) $display("FAIL rnd_psum@%0d: got %h want %h", k, o_psum, e.psum);
      else n_pass++;
`ifdef FS_STALL_CNT_EN
      n_total++;
      if (o_stall_cnt !== 16'(stall_model)) $display("FAIL rnd_stall@%0d: got %0d want %0d", k, o_stall_cnt, stall_model);
      else n_pass++;
`endif
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; main_rdy = 1'b0; fs_ack = 1'b0;
    mode = '0; inumt = '0; wnumt = '0; psum_mode = '0; psum_sel = '0;
    in_w = '0; wt_w = '0; ps_w = '0;
    #1;
    test_reset();
    test_mask();
    test_psum();
    test_fill();
    test_back_to_back();
`ifdef FS_STALL_CNT_EN
    test_stall();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
